// File: rtl/pwm_multi.sv
// N-channel PWM peripheral: one shared prescaler and period counter, per-channel duty and polarity.
// PERIOD/DUTY writes go to shadow registers and reach the counter only at a period wrap.
module pwm_multi #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PRESC_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic [NUM_CH-1:0] pwm_o,
    input  logic [31:0]       addr_32b_i,
    input  logic              wren_i,
    input  logic              rden_i,
    input  logic [31:0]       din_32b_i,
    output logic [31:0]       dout_32b_o,
    output logic              dout_32b_valid_o,
    output logic              interrupt_o
);

    localparam int unsigned IDX_W     = 5;
    localparam int unsigned DUTY_BASE = 4;
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_PRESC  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_PERIOD = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(3);

    logic [IDX_W-1:0]   idx_c;
    logic [31:0]        rdata_c;
    logic               unused_c;

    logic               run_q, run_d;
    logic               irq_en_q, irq_en_d;
    logic [NUM_CH-1:0]  pol_q, pol_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   duty_q [NUM_CH];
    logic [CNT_W-1:0]   duty_d [NUM_CH];
    logic               wrap_q, wrap_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_act_q, period_act_d;
    logic [CNT_W-1:0]   duty_act_q [NUM_CH];
    logic [CNT_W-1:0]   duty_act_d [NUM_CH];
    logic [NUM_CH-1:0]  pwm_q, pwm_d;
    logic [31:0]        dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               irq_q, irq_d;
    logic               tick_c;
    logic               wrap_set_c;

    assign idx_c    = addr_32b_i[6:2];
    assign unused_c = ^{addr_32b_i, din_32b_i};

    // Read mux: unmapped offsets and channels beyond NUM_CH read as zero
    always_comb begin
        rdata_c = '0;
        case (idx_c)
            IDX_CTRL: begin
                rdata_c[0]           = run_q;
                rdata_c[1]           = irq_en_q;
                rdata_c[8 +: NUM_CH] = pol_q;
            end
            IDX_PRESC:  rdata_c = 32'(presc_q);
            IDX_PERIOD: rdata_c = 32'(period_q);
            IDX_STATUS: rdata_c = 32'(wrap_q);
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (idx_c == IDX_W'(DUTY_BASE + i)) begin
                        rdata_c = 32'(duty_q[i]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        run_d        = run_q;
        irq_en_d     = irq_en_q;
        pol_d        = pol_q;
        presc_d      = presc_q;
        period_d     = period_q;
        duty_d       = duty_q;
        presc_cnt_d  = presc_cnt_q;
        cnt_d        = cnt_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        pwm_d        = '0;
        tick_c       = 1'b0;
        wrap_set_c   = 1'b0;

        // Counters run only while enabled; stopped state keeps active copies tracking the shadows
        if (run_q) begin
            if (presc_cnt_q == presc_q) begin
                tick_c      = 1'b1;
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_W'(1);
            end
            if (tick_c) begin
                if (cnt_q == period_act_q) begin
                    cnt_d        = '0;
                    period_act_d = period_q;
                    duty_act_d   = duty_q;
                    wrap_set_c   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            presc_cnt_d  = '0;
            cnt_d        = '0;
            period_act_d = period_q;
            duty_act_d   = duty_q;
        end

        if (wren_i) begin
            case (idx_c)
                IDX_CTRL: begin
                    run_d    = din_32b_i[0];
                    irq_en_d = din_32b_i[1];
                    pol_d    = din_32b_i[8 +: NUM_CH];
                end
                IDX_PRESC:  presc_d  = PRESC_W'(din_32b_i);
                IDX_PERIOD: period_d = CNT_W'(din_32b_i);
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_c == IDX_W'(DUTY_BASE + i)) begin
                            duty_d[i] = CNT_W'(din_32b_i);
                        end
                    end
                end
            endcase
        end

        // A wrap in the same cycle as the W1C clear keeps the flag set
        wrap_d = wrap_set_c |
                 (wrap_q & ~(wren_i & (idx_c == IDX_STATUS) & din_32b_i[0]));

        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (run_q & (cnt_q < duty_act_q[i])) ^ pol_q[i];
        end

        valid_d = wren_i | rden_i;
        dout_d  = (rden_i & ~wren_i) ? rdata_c : dout_q;
        irq_d   = wrap_d & irq_en_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            pol_q        <= '0;
            presc_q      <= '0;
            period_q     <= '0;
            wrap_q       <= 1'b0;
            presc_cnt_q  <= '0;
            cnt_q        <= '0;
            period_act_q <= '0;
            pwm_q        <= '0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            irq_q        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            run_q        <= run_d;
            irq_en_q     <= irq_en_d;
            pol_q        <= pol_d;
            presc_q      <= presc_d;
            period_q     <= period_d;
            wrap_q       <= wrap_d;
            presc_cnt_q  <= presc_cnt_d;
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            pwm_q        <= pwm_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            irq_q        <= irq_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= duty_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign pwm_o            = pwm_q;
    assign dout_32b_o       = dout_q;
    assign dout_32b_valid_o = valid_q;
    assign interrupt_o      = irq_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios plus random bus traffic, all outputs compared every cycle
// against a register-map reference model.
module tb_pwm_multi;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned PRESC_W    = 16;
    localparam int unsigned CNT_MASK   = 32'((64'd1 << CNT_W) - 64'd1);
    localparam int unsigned PRESC_MASK = 32'((64'd1 << PRESC_W) - 64'd1);

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic [NUM_CH-1:0] pwm_o;
    logic [31:0]       addr_32b_i = '0;
    logic              wren_i = 1'b0;
    logic              rden_i = 1'b0;
    logic [31:0]       din_32b_i = '0;
    logic [31:0]       dout_32b_o;
    logic              dout_32b_valid_o;
    logic              interrupt_o;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .pwm_o            (pwm_o),
        .addr_32b_i       (addr_32b_i),
        .wren_i           (wren_i),
        .rden_i           (rden_i),
        .din_32b_i        (din_32b_i),
        .dout_32b_o       (dout_32b_o),
        .dout_32b_valid_o (dout_32b_valid_o),
        .interrupt_o      (interrupt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register file, shared timebase and output pins
    bit          m_run, m_irq_en, m_wrap, m_valid, m_irq;
    bit [NUM_CH-1:0] m_pol, m_pwm;
    int unsigned m_presc, m_period, m_presc_cnt, m_cnt, m_period_act;
    int unsigned m_duty [NUM_CH];
    int unsigned m_duty_act [NUM_CH];
    logic [31:0] m_dout;

    task automatic model_reset();
        m_run = 0; m_irq_en = 0; m_wrap = 0; m_valid = 0; m_irq = 0;
        m_pol = '0; m_pwm = '0; m_dout = '0;
        m_presc = 0; m_period = 0; m_presc_cnt = 0; m_cnt = 0; m_period_act = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 0;
            m_duty_act[i] = 0;
        end
    endtask

    task automatic model_step();
        int unsigned idx;
        logic [31:0] rv;
        bit wrapped, w1c;
        idx = int'(addr_32b_i[6:2]);
        rv = '0;
        wrapped = 0;
        w1c = 0;
        if (idx == 0) rv = 32'(m_run) | (32'(m_irq_en) << 1) | (32'(m_pol) << 8);
        else if (idx == 1) rv = m_presc;
        else if (idx == 2) rv = m_period;
        else if (idx == 3) rv = 32'(m_wrap);
        else if (idx >= 4 && idx < 4 + NUM_CH) rv = m_duty[idx-4];

        for (int i = 0; i < NUM_CH; i++)
            m_pwm[i] = (m_run && (m_cnt < m_duty_act[i])) ^ m_pol[i];
        m_valid = wren_i || rden_i;
        if (rden_i && !wren_i) m_dout = rv;

        if (m_run) begin
            if (m_presc_cnt == m_presc) begin
                m_presc_cnt = 0;
                if (m_cnt == m_period_act) begin
                    m_cnt = 0;
                    m_period_act = m_period;
                    for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty[i];
                    wrapped = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_presc_cnt = (m_presc_cnt + 1) & PRESC_MASK;
            end
        end else begin
            m_presc_cnt = 0;
            m_cnt = 0;
            m_period_act = m_period;
            for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty[i];
        end

        if (wren_i) begin
            if (idx == 0) begin
                m_run = din_32b_i[0];
                m_irq_en = din_32b_i[1];
                m_pol = din_32b_i[8 +: NUM_CH];
            end else if (idx == 1) m_presc = din_32b_i & PRESC_MASK;
            else if (idx == 2) m_period = din_32b_i & CNT_MASK;
            else if (idx == 3) w1c = din_32b_i[0];
            else if (idx >= 4 && idx < 4 + NUM_CH) m_duty[idx-4] = din_32b_i & CNT_MASK;
        end
        if (wrapped) m_wrap = 1;
        else if (w1c) m_wrap = 0;
        m_irq = m_wrap && m_irq_en;
    endtask

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) model_reset();
        else model_step();
    end

    // Every output compared against the model on every falling edge outside reset
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            check("pwm_o", 32'(pwm_o), 32'(m_pwm));
            check("dout", dout_32b_o, m_dout);
            check("valid", 32'(dout_32b_valid_o), 32'(m_valid));
            check("irq", 32'(interrupt_o), 32'(m_irq));
        end
    end

    // Bus tasks are entered at a falling edge and return at the next one
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr_32b_i = a; din_32b_i = d; wren_i = 1'b1;
        @(negedge clk_i);
        wren_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] q);
        addr_32b_i = a; rden_i = 1'b1;
        @(negedge clk_i);
        rden_i = 1'b0;
        q = dout_32b_o;
    endtask

    task automatic bus_wrrd(input logic [31:0] a, input logic [31:0] d);
        addr_32b_i = a; din_32b_i = d; wren_i = 1'b1; rden_i = 1'b1;
        @(negedge clk_i);
        wren_i = 1'b0; rden_i = 1'b0;
    endtask

    task automatic count_high(input int ch, input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            @(negedge clk_i);
            hi += int'(pwm_o[ch]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int hi, waited;
        bit seen;

        #3;
        check("rst_pwm", 32'(pwm_o), 32'd0);
        check("rst_dout", dout_32b_o, 32'd0);
        check("rst_valid", 32'(dout_32b_valid_o), 32'd0);
        check("rst_irq", 32'(interrupt_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Basic 3/10 duty at full clock rate
        bus_wr(32'h04, 32'd0);
        bus_wr(32'h08, 32'd9);
        bus_wr(32'h10, 32'd3);
        bus_wr(32'h00, 32'h1);
        repeat (5) @(negedge clk_i);
        count_high(0, 20, hi);
        check("t1_high_ch0", 32'(hi), 32'd6);

        // Prescaled: each count lasts 5 clocks, period of 4 counts
        bus_wr(32'h00, 32'h0);
        bus_wr(32'h04, 32'd4);
        bus_wr(32'h08, 32'd3);
        bus_wr(32'h14, 32'd2);
        bus_wr(32'h00, 32'h1);
        repeat (3) @(negedge clk_i);
        count_high(1, 40, hi);
        check("t2_high_ch1", 32'(hi), 32'd20);

        // Mid-period duty change only reaches the output after the next wrap
        bus_wr(32'h00, 32'h0);
        bus_wr(32'h04, 32'd0);
        bus_wr(32'h08, 32'd9);
        bus_wr(32'h10, 32'd3);
        bus_wr(32'h00, 32'h1);
        repeat (14) @(negedge clk_i);
        bus_wr(32'h10, 32'd7);
        bus_rd(32'h10, rd);
        check("t3_duty_rd", rd, 32'd7);
        repeat (11) @(negedge clk_i);
        count_high(0, 10, hi);
        check("t3_high_ch0", 32'(hi), 32'd7);

        // Duty extremes and inverted channel 2
        bus_wr(32'h00, 32'h0);
        bus_wr(32'h10, 32'd0);
        bus_wr(32'h14, 32'd10);
        bus_wr(32'h18, 32'd0);
        bus_wr(32'h00, 32'h401);
        repeat (12) @(negedge clk_i);
        count_high(0, 10, hi);
        check("t4_duty0", 32'(hi), 32'd0);
        count_high(1, 10, hi);
        check("t4_duty_full", 32'(hi), 32'd10);
        count_high(2, 10, hi);
        check("t4_inverted", 32'(hi), 32'd10);
        bus_wr(32'h00, 32'h400);
        @(negedge clk_i);
        check("t4_idle_pol", 32'(pwm_o), 32'h4);

        // Interrupt with a W1C landing on the wrap edge, then a later clear
        bus_wr(32'h0C, 32'h1);
        bus_rd(32'h0C, rd);
        check("t5_flag_clr0", rd, 32'd0);
        bus_wr(32'h00, 32'h3);
        repeat (9) @(negedge clk_i);
        bus_wr(32'h0C, 32'h1);
        bus_rd(32'h0C, rd);
        check("t5_set_wins", rd, 32'd1);
        check("t5_irq_high", 32'(interrupt_o), 32'd1);
        bus_wr(32'h00, 32'h0);
        bus_wr(32'h0C, 32'h1);
        bus_rd(32'h0C, rd);
        check("t5_flag_clr", rd, 32'd0);
        check("t5_irq_low", 32'(interrupt_o), 32'd0);
        bus_wr(32'h00, 32'h3);
        seen = 0;
        waited = 0;
        while (!seen && waited < 40) begin
            @(negedge clk_i);
            seen = interrupt_o;
            waited++;
        end
        check("t5_irq_rise", 32'(seen), 32'd1);

        // Bus corner cases and async reset
        bus_rd(32'h08, rd);
        check("t6_period_rd", rd, 32'd9);
        bus_wrrd(32'h08, 32'd5);
        check("t6_wrrd_hold", dout_32b_o, 32'd9);
        check("t6_wrrd_valid", 32'(dout_32b_valid_o), 32'd1);
        @(negedge clk_i);
        check("t6_single_valid", 32'(dout_32b_valid_o), 32'd0);
        bus_rd(32'h08, rd);
        check("t6_period_new", rd, 32'd5);
        bus_rd(32'h40, rd);
        check("t6_unmapped", rd, 32'd0);
        bus_wr(32'h00, 32'hF03);
        repeat (7) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("t6_rst_pwm", 32'(pwm_o), 32'd0);
        check("t6_rst_dout", dout_32b_o, 32'd0);
        check("t6_rst_valid", 32'(dout_32b_valid_o), 32'd0);
        check("t6_rst_irq", 32'(interrupt_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Random register traffic, checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            int unsigned op, ix;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            ix = $urandom_range(0, 9);
            if (ix == 9) ix = 16;
            case (ix)
                0: d = 32'(($urandom_range(0, 7) != 0) ? 1 : 0) | 32'($urandom_range(0, 1) << 1)
                       | 32'($urandom_range(0, 15) << 8);
                1: d = 32'($urandom_range(0, 3));
                2: d = 32'($urandom_range(0, 12));
                3: d = 32'($urandom_range(0, 1));
                default: d = 32'($urandom_range(0, 14));
            endcase
            if (ix == 16) d = $urandom;
            if (op == 0) bus_wr(32'(ix << 2), d);
            else if (op == 1) bus_rd(32'(ix << 2), rd);
            else if (op == 2) bus_wrrd(32'(ix << 2), d);
            else @(negedge clk_i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
